// File: rtl/butterfly_seq_pkg.sv
// Shared types for the butterfly stage sequencer: FSM state encoding and a
// width helper used to size FIFO pointers and occupancy counters.
package butterfly_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

    // Bits needed to index n items; never returns zero so a depth-1 FIFO
    // still gets a legal one-bit pointer.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/butterfly_seq_idx_fifo.sv
// In-order FIFO holding the {idx_a, idx_b} pair of every butterfly in flight.
// Pushes while full and pops while empty are ignored; reset flushes contents.
module butterfly_seq_idx_fifo
    import butterfly_seq_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int DEPTH = 2,
    localparam int PW = idx_width(DEPTH),
    localparam int CW = idx_width(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage, pointers and occupancy; contents cleared so the head reads 0 after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/butterfly_stage_sequencer.sv
// Sequences one radix-2 FFT stage through a shared butterfly: issues read and
// twiddle indices on the recv handshake, tracks in-flight butterflies in an
// in-order index FIFO and emits writeback indices on the send handshake.
// Build option BUTTERFLY_SEQ_ALL_STAGES_EN: run stages 0..LOG_N-1 back-to-back
// per start, ignoring the stage input; otherwise one stage per start.
//
// Handshakes: a transfer happens in a cycle where valid and ready are both
// high; valid never depends on ready; issue indices hold until the transfer.
module butterfly_stage_sequencer
    import butterfly_seq_pkg::*;
#(
    parameter int N_SAMPLES = 8,
    parameter int LOG_N     = 3,
    parameter int MAX_OUT   = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [$clog2(LOG_N)-1:0]   stage,
    output logic                       busy,
    output logic                       done,
    output logic                       bf_recv_val,
    input  logic                       bf_recv_rdy,
    output logic [LOG_N-1:0]           idx_a,
    output logic [LOG_N-1:0]           idx_b,
    output logic [LOG_N-2:0]           tw_idx,
    input  logic                       bf_send_val,
    output logic                       bf_send_rdy,
    input  logic                       wb_rdy,
    output logic                       wb_en,
    output logic [LOG_N-1:0]           wb_idx_a,
    output logic [LOG_N-1:0]           wb_idx_b
);

    localparam int SW   = $clog2(LOG_N);
    localparam int KW   = LOG_N - 1;
    localparam int CW   = idx_width(MAX_OUT + 1);
    localparam int HALF = N_SAMPLES / 2;

    seq_state_e           state;
    seq_state_e           state_nxt;
    logic [KW-1:0]        k;
    logic [KW-1:0]        k_nxt;
    logic [SW-1:0]        s;
    logic [SW-1:0]        s_nxt;
    logic                 fire;
    logic                 push;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CW-1:0]        fifo_count;
    logic [CW-1:0]        cnt_nxt;
    logic                 recv_val_nxt;
    logic [3*LOG_N-2:0]   idx_nxt;

    // Index generation for butterfly kk of stage ss, packed as {a, b, tw}.
    function automatic logic [3*LOG_N-2:0] bf_indices(input logic [KW-1:0] kk,
                                                      input logic [SW-1:0] ss);
        logic [LOG_N-1:0] kext;
        logic [LOG_N-1:0] span;
        logic [LOG_N-1:0] pos;
        logic [LOG_N-1:0] grp;
        logic [LOG_N-1:0] a;
        logic [LOG_N-1:0] b;
        logic [KW-1:0]    t;
        kext = LOG_N'(kk);
        span = LOG_N'(1) << ss;
        pos  = kext & (span - 1'b1);
        grp  = kext >> ss;
        a    = (grp << (ss + 1)) | pos;
        b    = a + span;
        t    = KW'(pos << (LOG_N - 1 - int'(ss)));
        return {a, b, t};
    endfunction

    butterfly_seq_idx_fifo #(
        .WIDTH (2 * LOG_N),
        .DEPTH (MAX_OUT)
    ) u_idx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   ({idx_a, idx_b}),
        .pop   (wb_en),
        .dout  ({wb_idx_a, wb_idx_b}),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign fire        = bf_recv_val && bf_recv_rdy;
    assign push        = fire && !fifo_full;
    assign bf_send_rdy = wb_rdy && !fifo_empty;
    assign wb_en       = bf_send_val && bf_send_rdy;
    assign busy        = (state == ISSUE) || (state == DRAIN);
    assign done        = (state == DONE);

    // Occupancy after this edge decides whether the next cycle may issue,
    // so a pop in a full cycle frees a slot only from the following cycle.
    assign cnt_nxt      = fifo_count + CW'(push) - CW'(wb_en);
    assign recv_val_nxt = (state_nxt == ISSUE) && (cnt_nxt < CW'(MAX_OUT));
    assign idx_nxt      = bf_indices(k_nxt, s_nxt);

`ifdef BUTTERFLY_SEQ_ALL_STAGES_EN
    logic unused_stage;
    assign unused_stage = ^stage;
`endif

    // Next-state, butterfly counter and stage selection.
    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        s_nxt     = s;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ISSUE;
                    k_nxt     = '0;
`ifdef BUTTERFLY_SEQ_ALL_STAGES_EN
                    s_nxt     = '0;
`else
                    s_nxt     = (int'(stage) >= LOG_N) ? SW'(LOG_N - 1) : stage;
`endif
                end
            end
            ISSUE: begin
                if (push) begin
                    k_nxt = k + 1'b1;
                    if (k == KW'(HALF - 1)) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (cnt_nxt == '0) begin
`ifdef BUTTERFLY_SEQ_ALL_STAGES_EN
                    // Next stage reads what this one wrote, so it starts only once drained.
                    if (s == SW'(LOG_N - 1)) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = ISSUE;
                        s_nxt     = s + 1'b1;
                        k_nxt     = '0;
                    end
`else
                    state_nxt = DONE;
`endif
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, counters and the registered issue request with its indices.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            k           <= '0;
            s           <= '0;
            bf_recv_val <= 1'b0;
            idx_a       <= '0;
            idx_b       <= '0;
            tw_idx      <= '0;
        end else begin
            state       <= state_nxt;
            k           <= k_nxt;
            s           <= s_nxt;
            bf_recv_val <= recv_val_nxt;
            {idx_a, idx_b, tw_idx} <= idx_nxt;
        end
    end

endmodule

// File: tb/tb_butterfly_stage_sequencer.sv
// Self-checking bench for butterfly_stage_sequencer (N_SAMPLES=8, MAX_OUT=2).
// A behavioural butterfly returns results in issue order; expected issue
// tuples are queued at start and expected writebacks are queued on each issue.
// Build option BUTTERFLY_SEQ_ALL_STAGES_EN switches the expected run to all stages.
module tb_butterfly_stage_sequencer;

    localparam int MAX_OUT = 2;
`ifdef BUTTERFLY_SEQ_ALL_STAGES_EN
    localparam int NST = 3;
`else
    localparam int NST = 1;
`endif

    logic       clk;
    logic       reset;
    logic       start;
    logic [1:0] stage;
    logic       busy;
    logic       done;
    logic       bf_recv_val;
    logic       bf_recv_rdy;
    logic [2:0] idx_a;
    logic [2:0] idx_b;
    logic [1:0] tw_idx;
    logic       bf_send_val;
    logic       bf_send_rdy;
    logic       wb_rdy;
    logic       wb_en;
    logic [2:0] wb_idx_a;
    logic [2:0] wb_idx_b;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q[$];
    logic [5:0] exp_wb_q[$];

    butterfly_stage_sequencer #(
        .N_SAMPLES (8),
        .LOG_N     (3),
        .MAX_OUT   (MAX_OUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stage       (stage),
        .busy        (busy),
        .done        (done),
        .bf_recv_val (bf_recv_val),
        .bf_recv_rdy (bf_recv_rdy),
        .idx_a       (idx_a),
        .idx_b       (idx_b),
        .tw_idx      (tw_idx),
        .bf_send_val (bf_send_val),
        .bf_send_rdy (bf_send_rdy),
        .wb_rdy      (wb_rdy),
        .wb_en       (wb_en),
        .wb_idx_a    (wb_idx_a),
        .wb_idx_b    (wb_idx_b)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference indices: a group of 2*span samples, butterfly at offset k%span.
    function automatic logic [7:0] exp_issue(input int st, input int k);
        int span;
        int a;
        int b;
        int tw;
        span = 1 << st;
        a    = (k / span) * 2 * span + (k % span);
        b    = a + span;
        tw   = (k % span) * 4 / span;
        return {3'(a), 3'(b), 2'(tw)};
    endfunction

    // Drives one run and scores every cycle. Entered and left at posedge+#1.
    task automatic run_stage(input int stg, input int rdy_pct, input int wbrdy_pct,
                             input int send_pct, input int hold, input int blk_lo,
                             input int blk_hi, input int poke,
                             output int hold_issues, output int wb_at_rise);
        int first_st;
        int total;
        int issued;
        int pend;
        int cyc;
        bit finished;
        bit exp_done;
        bit fire;
        bit wbn;
        logic [7:0] e;
        logic [5:0] w;
`ifdef BUTTERFLY_SEQ_ALL_STAGES_EN
        first_st = 0;
`else
        first_st = (stg >= 3) ? 2 : stg;
`endif
        exp_q.delete();
        exp_wb_q.delete();
        for (int st = first_st; st < first_st + NST; st++) begin
            for (int k = 0; k < 4; k++) begin
                exp_q.push_back(exp_issue(st, k));
            end
        end
        total       = exp_q.size();
        issued      = 0;
        pend        = 0;
        cyc         = 0;
        finished    = 1'b0;
        exp_done    = 1'b0;
        hold_issues = 0;
        wb_at_rise  = 0;

        start = 1'b1;
        stage = 2'(stg);
        @(posedge clk);
        #1;
        start = 1'b0;

        while (!finished && cyc < 400) begin
            bf_recv_rdy = ($urandom_range(99) < rdy_pct);
            wb_rdy      = (cyc >= blk_lo && cyc <= blk_hi) ? 1'b0 : ($urandom_range(99) < wbrdy_pct);
            bf_send_val = (pend > 0) && (cyc >= hold) && ($urandom_range(99) < send_pct);
            start       = (cyc == poke);
            stage       = (cyc == poke) ? 2'(stg + 1) : 2'(stg);
            @(negedge clk);

            checks++;
            if (done !== exp_done) begin
                errors++;
                $display("FAIL done cyc=%0d: got %b expected %b", cyc, done, exp_done);
            end
            checks++;
            if (busy !== !exp_done) begin
                errors++;
                $display("FAIL busy cyc=%0d: got %b expected %b", cyc, busy, !exp_done);
            end
            if (done === 1'b1) finished = 1'b1;

            if (pend == MAX_OUT) begin
                checks++;
                if (bf_recv_val !== 1'b0) begin
                    errors++;
                    $display("FAIL full_stall cyc=%0d: bf_recv_val=%b expected 0 with %0d in flight",
                             cyc, bf_recv_val, pend);
                end
            end
            checks++;
            if (bf_send_rdy !== (wb_rdy && pend > 0)) begin
                errors++;
                $display("FAIL send_rdy cyc=%0d: got %b expected %b", cyc, bf_send_rdy, wb_rdy && pend > 0);
            end
            checks++;
            if (wb_en !== (bf_send_val && wb_rdy && pend > 0)) begin
                errors++;
                $display("FAIL wb_en cyc=%0d: got %b expected %b", cyc, wb_en,
                         bf_send_val && wb_rdy && pend > 0);
            end

            fire = (bf_recv_val === 1'b1) && bf_recv_rdy;
            wbn  = (wb_en === 1'b1);
            if (fire) begin
                if (issued > 0 && issued % 4 == 0) begin
                    checks++;
                    if (pend != 0) begin
                        errors++;
                        $display("FAIL stage_order: issue %0d while %0d writebacks outstanding, expected 0",
                                 issued, pend);
                    end
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_issue cyc=%0d: got a=%0d b=%0d, expected no issue", cyc, idx_a, idx_b);
                end else begin
                    e = exp_q.pop_front();
                    if ({idx_a, idx_b, tw_idx} !== e) begin
                        errors++;
                        $display("FAIL issue_idx #%0d: got a=%0d b=%0d tw=%0d expected a=%0d b=%0d tw=%0d",
                                 issued, idx_a, idx_b, tw_idx, e[7:5], e[4:2], e[1:0]);
                    end
                    exp_wb_q.push_back(e[7:2]);
                end
            end
            if (wbn) begin
                checks++;
                if (exp_wb_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_wb cyc=%0d: got a=%0d b=%0d, expected no writeback", cyc, wb_idx_a, wb_idx_b);
                end else begin
                    w = exp_wb_q.pop_front();
                    if ({wb_idx_a, wb_idx_b} !== w) begin
                        errors++;
                        $display("FAIL wb_idx cyc=%0d: got a=%0d b=%0d expected a=%0d b=%0d",
                                 cyc, wb_idx_a, wb_idx_b, w[5:3], w[2:0]);
                    end
                end
            end
            if (cyc == blk_hi + 1 && wbn) wb_at_rise = 1;
            if (cyc < hold && fire) hold_issues++;

            exp_done = wbn && !fire && (pend == 1) && (issued == total);
            if (fire) issued++;
            pend = pend + int'(fire) - int'(wbn);
            @(posedge clk);
            #1;
            cyc++;
        end

        start       = 1'b0;
        bf_send_val = 1'b0;
        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL run_timeout stage=%0d: done not seen, got %0d issues expected %0d", stg, issued, total);
        end
        checks++;
        if (exp_q.size() != 0 || exp_wb_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: got %0d issues and %0d writebacks pending, expected 0 and 0",
                     exp_q.size(), exp_wb_q.size());
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL after_done: got done=%b busy=%b expected 0 0", done, busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        start       = 1'b0;
        stage       = 2'd0;
        bf_recv_rdy = 1'b1;
        bf_send_val = 1'b1;
        wb_rdy      = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, bf_recv_val, bf_send_rdy, wb_en} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got busy/done/recv_val/send_rdy/wb_en=%b expected 00000",
                     {busy, done, bf_recv_val, bf_send_rdy, wb_en});
        end
        checks++;
        if ({idx_a, idx_b, tw_idx, wb_idx_a, wb_idx_b} !== 14'b0) begin
            errors++;
            $display("FAIL reset_idx: got a=%0d b=%0d tw=%0d wa=%0d wb=%0d expected all 0",
                     idx_a, idx_b, tw_idx, wb_idx_a, wb_idx_b);
        end
        reset       = 1'b0;
        bf_send_val = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, bf_recv_val} !== 2'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%b recv_val=%b expected 0 0", busy, bf_recv_val);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_stage_patterns();
        int hi;
        int wr;
        run_stage(1, 100, 100, 100, 0, -1, -1, -1, hi, wr);
        run_stage(2, 100, 100, 100, 0, -1, -1, -1, hi, wr);
        run_stage(0, 100, 100, 100, 0, -1, -1, -1, hi, wr);
        run_stage(3, 100, 100, 100, 0, -1, -1, -1, hi, wr);
    endtask

    task automatic test_fifo_full();
        int hi;
        int wr;
        run_stage(1, 100, 100, 100, 8, -1, -1, -1, hi, wr);
        checks++;
        if (hi != MAX_OUT) begin
            errors++;
            $display("FAIL fifo_full_issues: got %0d issues while results held, expected %0d", hi, MAX_OUT);
        end
    endtask

    task automatic test_wb_stall();
        int hi;
        int wr;
        run_stage(1, 100, 100, 100, 0, 2, 6, -1, hi, wr);
        checks++;
        if (wr != 1) begin
            errors++;
            $display("FAIL wb_on_rdy_rise: got wb_en=%0d in the wb_rdy rise cycle, expected 1", wr);
        end
    endtask

    task automatic test_reset_mid_run();
        int hi;
        int wr;
        start       = 1'b1;
        stage       = 2'd1;
        bf_recv_rdy = 1'b1;
        bf_send_val = 1'b0;
        wb_rdy      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if ({idx_a, idx_b, bf_recv_val, busy} !== {3'd4, 3'd6, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL pre_reset: got a=%0d b=%0d recv_val=%b busy=%b expected 4 6 0 1",
                     idx_a, idx_b, bf_recv_val, busy);
        end
        bf_send_val = 1'b1;
        reset       = 1'b1;
        #1;
        checks++;
        if ({busy, done, bf_recv_val, bf_send_rdy, wb_en} !== 5'b0) begin
            errors++;
            $display("FAIL mid_reset_ctrl: got busy/done/recv_val/send_rdy/wb_en=%b expected 00000",
                     {busy, done, bf_recv_val, bf_send_rdy, wb_en});
        end
        checks++;
        if ({idx_a, idx_b, tw_idx, wb_idx_a, wb_idx_b} !== 14'b0) begin
            errors++;
            $display("FAIL mid_reset_idx: got a=%0d b=%0d tw=%0d wa=%0d wb=%0d expected all 0",
                     idx_a, idx_b, tw_idx, wb_idx_a, wb_idx_b);
        end
        bf_send_val = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        run_stage(1, 100, 100, 100, 0, -1, -1, 3, hi, wr);
    endtask

    task automatic test_random();
        int hi;
        int wr;
        for (int r = 0; r < 6; r++) begin
            run_stage($urandom_range(3), $urandom_range(100, 30), $urandom_range(100, 30),
                      $urandom_range(100, 30), 0, -1, -1, $urandom_range(10, 1), hi, wr);
        end
    endtask

    initial begin
        test_reset();
        test_stage_patterns();
        test_fifo_full();
        test_wb_stall();
        test_reset_mid_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
